// File: rtl/axi_lite_selftest_master.sv
// AXI4-Lite self-test master: writes a pattern over a word window,
// reads it back, compares, and reports pass/fail with a watchdog.
module axi_lite_selftest_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int C_NUM_WORDS = 4,
  parameter logic [31:0] C_SEED = 32'h0101FFFF,
  parameter int C_TIMEOUT = 1024
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic start,
  input  logic mode,
  input  logic pattern,
  output logic busy,
  output logic done,
  output logic pass,
  output logic timeout,
  output logic [15:0] err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] first_err_addr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0] M_AXI_AWPROT,
  output logic M_AXI_AWVALID,
  input  logic M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic M_AXI_WVALID,
  input  logic M_AXI_WREADY,
  input  logic [1:0] M_AXI_BRESP,
  input  logic M_AXI_BVALID,
  output logic M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0] M_AXI_ARPROT,
  output logic M_AXI_ARVALID,
  input  logic M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0] M_AXI_RRESP,
  input  logic M_AXI_RVALID,
  output logic M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SH = (DW == 64) ? 3 : 2;
  localparam logic [8:0] LAST = 9'(C_NUM_WORDS - 1);
  localparam logic [31:0] WD_MAX = 32'(C_TIMEOUT - 1);
  localparam logic [31:0] POLY = 32'h80200003;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
  } state_t;

  state_t state, state_n;

  logic [8:0] idx;
  logic [31:0] p, p_next;
  logic mode_q, pat_q;
  logic aw_ok, w_ok;
  logic [31:0] wd;
  logic [15:0] errs;
  logic to_q;
  logic [AW-1:0] fea, addr;
  logic [DW-1:0] pdata;
  logic active, last, go;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  logic wd_exp;
  logic b_err, rr_err, rd_err;
  logic [1:0] inc;
  logic [16:0] sum;

  assign addr = C_BASE_ADDR + (AW'(idx) << SH);
  assign last = (idx == LAST);

  assign p_next = pat_q
    ? ({1'b0, p[31:1]} ^ (p[0] ? POLY : 32'h0))
    : p + 32'd1;

  // Wide buses carry the inverted pattern in the upper half
  generate
    if (DW == 64) begin : g_d64
      assign pdata = {~p, p};
    end else begin : g_d32
      assign pdata = p;
    end
  endgenerate

  assign active = (state == WR_REQ) || (state == WR_RESP)
               || (state == RD_REQ) || (state == RD_RESP);

  assign aw_hs = (state == WR_REQ) && !aw_ok && M_AXI_AWREADY;
  assign w_hs  = (state == WR_REQ) && !w_ok && M_AXI_WREADY;
  assign b_hs  = (state == WR_RESP) && M_AXI_BVALID;
  assign ar_hs = (state == RD_REQ) && M_AXI_ARREADY;
  assign r_hs  = (state == RD_RESP) && M_AXI_RVALID;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  assign wd_exp = active && !any_hs && (wd == WD_MAX);

  assign b_err  = b_hs && (M_AXI_BRESP != 2'b00);
  assign rr_err = r_hs && (M_AXI_RRESP != 2'b00);
  assign rd_err = r_hs && (M_AXI_RDATA != pdata);
  assign inc = 2'(b_err) + 2'(rr_err) + 2'(rd_err) + 2'(wd_exp);
  assign sum = {1'b0, errs} + {15'd0, inc};

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB = '1;

  assign err_count = errs;
  assign timeout = to_q;
  assign first_err_addr = fea;
  assign pass = done && (errs == 16'd0) && !to_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    go = 1'b0;
    busy = active;
    done = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_AWADDR = '0;
    M_AXI_WVALID = 1'b0;
    M_AXI_WDATA = '0;
    M_AXI_BREADY = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_ARADDR = '0;
    M_AXI_RREADY = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          go = 1'b1;
          state_n = WR_REQ;
        end
      end
      WR_REQ: begin
        M_AXI_AWVALID = !aw_ok;
        M_AXI_WVALID = !w_ok;
        if (!aw_ok) M_AXI_AWADDR = addr;
        if (!w_ok) M_AXI_WDATA = pdata;
        if ((aw_ok || M_AXI_AWREADY) && (w_ok || M_AXI_WREADY))
          state_n = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID)
          state_n = (!mode_q || last) ? RD_REQ : WR_REQ;
      end
      RD_REQ: begin
        M_AXI_ARVALID = 1'b1;
        M_AXI_ARADDR = addr;
        if (M_AXI_ARREADY) state_n = RD_RESP;
      end
      RD_RESP: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID)
          state_n = last ? DONE : (mode_q ? RD_REQ : WR_REQ);
      end
      default: state_n = IDLE;
    endcase
    // Abort wins; outputs fall when DONE is entered
    if (wd_exp) state_n = DONE;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || (state_n != state) || any_hs) wd <= '0;
    else if (active) wd <= wd + 32'd1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      idx <= '0;
      p <= '0;
      mode_q <= 1'b0;
      pat_q <= 1'b0;
      aw_ok <= 1'b0;
      w_ok <= 1'b0;
      errs <= '0;
      to_q <= 1'b0;
      fea <= '0;
    end else begin
      if (go) begin
        idx <= '0;
        p <= C_SEED;
        mode_q <= mode;
        pat_q <= pattern;
        aw_ok <= 1'b0;
        w_ok <= 1'b0;
        errs <= '0;
        to_q <= 1'b0;
        fea <= '0;
      end
      if (aw_hs) aw_ok <= 1'b1;
      if (w_hs) w_ok <= 1'b1;
      if (b_hs) begin
        aw_ok <= 1'b0;
        w_ok <= 1'b0;
        if (mode_q && last) begin
          idx <= '0;
          p <= C_SEED;
        end else if (mode_q) begin
          idx <= idx + 9'd1;
          p <= p_next;
        end
      end
      if (r_hs && !last) begin
        idx <= idx + 9'd1;
        p <= p_next;
      end
      if (inc != 2'd0) begin
        errs <= sum[16] ? 16'hFFFF : sum[15:0];
        if (errs == 16'd0) fea <= addr;
      end
      if (wd_exp) to_q <= 1'b1;
    end
  end

endmodule

// File: doc/axi_lite_selftest_master.md
# axi_lite_selftest_master

- Synthesizable AXI4-Lite master that runs a write/read-back/compare pass over a parametrised window of registers or BRAM words, then reports pass/fail.
- Patterns are incrementing or LFSR, with interleaved or block ordering, and it has a per-handshake watchdog.
- It sits in place of a simulation BFM in front of AXI-Lite slaves such as the BRAM FIFO controller, so the same check runs both in simulation and on hardware.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width; 32 or 64.
- C_BASE_ADDR, 32'h0000_0000, first word address.
- C_NUM_WORDS, 4, words tested; 1..256.
- C_SEED, 32'h0101FFFF, pattern seed; must be nonzero for LFSR.
- C_TIMEOUT, 1024, maximum cycles waited on any single handshake.
- ACLK in 1: clock.
- ARESET in 1: synchronous, active-high reset.
- start in 1: begin a pass; sampled only in IDLE.
- mode in 1: 0 = interleaved (write word i, read word i); 1 = block (write all words, then read all words).
- pattern in 1: 0 = incrementing (C_SEED+i); 1 = 32-bit Galois LFSR, polynomial 0x80200003.
- busy out 1: a pass is in progress.
- done out 1: pass finished; held until the next accepted start.
- pass out 1: done and err_count==0 and timeout==0.
- timeout out 1: the watchdog expired during this pass.
- err_count out 16: error count; saturates at 0xFFFF.
- first_err_addr out C_M_AXI_ADDR_WIDTH: address of the first error; 0 if no error.
- M_AXI_AW*/W*/B*/AR*/R* (master side), per AXI4-Lite:
  - AWADDR/ARADDR are C_M_AXI_ADDR_WIDTH wide.
  - WDATA/RDATA are C_M_AXI_DATA_WIDTH wide.
  - WSTRB is all ones.
  - AWPROT/ARPROT are 3'b000.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - start=1 clears err_count, first_err_addr and timeout, zeroes index i, and loads the pattern generator with C_SEED.
  - It then goes to WR_REQ.
- WR_REQ:
  - AWVALID and WVALID are asserted together. Each drops independently after its own handshake.
  - The state exits to WR_RESP when both handshakes have occurred.
  - AWADDR = C_BASE_ADDR + i*(C_M_AXI_DATA_WIDTH/8).
  - WDATA = p for 32-bit; {~p, p} for 64-bit.
- WR_RESP:
  - BREADY=1. On the B handshake, BRESP!=OKAY counts as an error.
  - Mode 0: go to RD_REQ.
  - Mode 1: go to WR_REQ with i+1. After the last word, go to RD_REQ with i=0 and the pattern generator reloaded with C_SEED.
- RD_REQ: ARVALID=1 until ARREADY.
- RD_RESP:
  - RREADY=1. On the R handshake, RRESP!=OKAY counts as one error.
  - RDATA != expected counts as one error.
  - If both are wrong on the same beat, two errors are counted.
  - Next state: next word, RD_REQ (mode 1), or DONE after word C_NUM_WORDS-1.
- The pattern advances once per word per phase:
  - Incrementing mode: p = C_SEED + i, mod 2^32.
  - LFSR mode: p shifts once per word.
- First error: first_err_addr latches the address of the current word; later errors leave it unchanged.
- Watchdog:
  - A counter is cleared on every state entry and on every handshake.
  - If it reaches C_TIMEOUT, timeout=1, err_count+1, all VALID/READY outputs deassert, and the FSM goes to DONE.
  - This is an abort; the slave must be reset before it is reused.
- DONE: start=1 begins a new pass, exactly as from IDLE.
- start is ignored while busy.

## Timing
- Reset values: all VALID/READY outputs 0, ADDR 0, WDATA 0, busy 0, done 0, pass 0, timeout 0, err_count 0, first_err_addr 0, state IDLE.
- ARESET asserted mid-pass: on the next edge, all outputs take their reset values. No outstanding transaction is completed.
- Start to bus: start sampled at edge N gives busy=1 and AWVALID=WVALID=1 from edge N+1.
- VALID signals and their address/data are stable until the handshake.
- READY signals are asserted only in their own response state.
- Throughput: with a slave that is always ready and responds one cycle after the handshake, each word takes 4 cycles in mode 0.
- Completion: done=1 and busy=0 from the edge after the final R handshake. pass is valid in the same cycle.
- Error reporting: err_count and first_err_addr update on the edge of the response handshake.
- Saturation: at 0xFFFF, err_count holds.

## Test plan
- Zero-wait RAM slave, mode 0, pattern 0, C_NUM_WORDS=4, base 0 → writes 0x0101FFFF, 0x01020000, 0x01020001, 0x01020002 at 0x0, 0x4, 0x8, 0xC, each read back immediately → done=1, pass=1, err_count=0, 16 cycles from the first AWVALID.
- Mode 1 with pattern 1 → all four AW handshakes precede the first AR; read data matches the LFSR sequence; pass=1.
- Slave inverts bit 0 of the read at 0x8 → err_count=1, first_err_addr=0x8, pass=0.
- Slave returns SLVERR on B at 0x4 and on R at 0xC → err_count=2, first_err_addr=0x4.
- Backpressure: AWREADY delayed 3 cycles, WREADY 0 cycles, random BVALID/RVALID stalls → AWADDR/AWVALID stable while waiting, WVALID dropped after its handshake, pass=1.
- Abort and recovery:
  - ARREADY held at 0 with C_TIMEOUT=16 → timeout=1, err_count=1, ARVALID=0 and done=1 within 17 cycles of ARVALID rising.
  - Then ARESET pulsed mid-pass → all outputs return to their reset values on the next edge, and a following start passes.
